// File: rtl/fb_write_scheduler_if.sv
// fb_write_scheduler_if: requester handshakes, clear control and registered framebuffer write port.
interface fb_write_scheduler_if #(parameter int AW = 19);
    logic          clear_req, clear_val;
    logic          m_valid, m_data, m_ready;
    logic [AW-1:0] m_addr;
    logic          t_valid, t_data, t_ready;
    logic [AW-1:0] t_addr;
    logic          fb_we, fb_din, busy, clear_done;
    logic [AW-1:0] fb_addr;
    modport master (
        output clear_req, clear_val, m_valid, m_addr, m_data, t_valid, t_addr, t_data,
        input  m_ready, t_ready, fb_we, fb_addr, fb_din, busy, clear_done
    );
    modport slave (
        input  clear_req, clear_val, m_valid, m_addr, m_data, t_valid, t_addr, t_data,
        output m_ready, t_ready, fb_we, fb_addr, fb_din, busy, clear_done
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: round-robin arbitration of mouse/text pixel writes plus a full-framebuffer clear.
module fb_write_scheduler #(
    parameter int FB_WORDS = 307200,
    parameter int AW       = 19
) (
    input logic               clk,
    input logic               rst,
    fb_write_scheduler_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam int         LASTI = FB_WORDS - 1;
    localparam logic [AW:0]   LIMIT = FB_WORDS[AW:0];
    localparam logic [AW-1:0] LAST  = LASTI[AW-1:0];
    logic [0:0]    state;
    logic          last_t, clr_val, arb, w_data, w_ok;
    logic [AW-1:0] cnt, w_addr;
    always_comb begin
        arb         = state == IDLE && !bus.clear_req;
        bus.m_ready = arb && bus.m_valid && (!bus.t_valid || last_t);
        bus.t_ready = arb && bus.t_valid && (!bus.m_valid || !last_t);
        w_addr      = bus.t_ready ? bus.t_addr : bus.m_addr;
        w_data      = bus.t_ready ? bus.t_data : bus.m_data;
        w_ok        = {1'b0, w_addr} < LIMIT;
    end
    // busy tracks clear writes in flight, so it spans exactly the FB_WORDS write cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_t         <= 1'b1;
            clr_val        <= 1'b0;
            cnt            <= '0;
            bus.fb_we      <= 1'b0;
            bus.fb_addr    <= '0;
            bus.fb_din     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            bus.fb_we      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.clear_done <= 1'b0;
            if (state == CLEAR) begin
                bus.fb_we      <= 1'b1;
                bus.fb_addr    <= cnt;
                bus.fb_din     <= clr_val;
                bus.busy       <= 1'b1;
                bus.clear_done <= cnt == LAST;
                state          <= cnt == LAST ? IDLE : CLEAR;
                cnt            <= cnt == LAST ? '0 : cnt + 1'b1;
            end else if (bus.clear_req) begin
                state   <= CLEAR;
                clr_val <= bus.clear_val;
                cnt     <= '0;
            end else if (bus.m_ready || bus.t_ready) begin
                last_t    <= bus.t_ready;
                bus.fb_we <= w_ok;
                if (w_ok) begin
                    bus.fb_addr <= w_addr;
                    bus.fb_din  <= w_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: vector table, clear/reset corner sequences and a randomized model check.
module tb_fb_write_scheduler;
    localparam int AW = 19;
    localparam int SW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    fb_write_scheduler_if #(.AW(AW)) bd ();
    fb_write_scheduler_if #(.AW(AW)) bs ();
    fb_write_scheduler #(.AW(AW)) d (.clk(clk), .rst(rst), .bus(bd));
    fb_write_scheduler #(.FB_WORDS(SW), .AW(AW)) s (.clk(clk), .rst(rst), .bus(bs));
    always #5 clk = ~clk;
    typedef struct {
        logic mv; logic [AW-1:0] ma; logic md;
        logic tv; logic [AW-1:0] ta; logic td;
        logic emr; logic etr; logic ewe; logic [AW-1:0] ea; logic ed;
    } vec_t;
    vec_t v [10];
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_rst;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask
    initial begin
        bit pm, pt, mclr, cval, mlt, arb, emr, etr, e_we, e_din, e_busy, e_done;
        int cidx, a, e_addr, wr, dn, ord, bc;
        {bd.clear_req, bd.clear_val, bd.m_valid, bd.m_addr, bd.m_data, bd.t_valid, bd.t_addr, bd.t_data} = '0;
        {bs.clear_req, bs.clear_val, bs.m_valid, bs.m_addr, bs.m_data, bs.t_valid, bs.t_addr, bs.t_data} = '0;
        v[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        v[1] = '{1, 10, 1, 1, 20, 0, 1, 0, 1, 10, 1};
        v[2] = '{1, 11, 0, 1, 20, 0, 0, 1, 1, 20, 0};
        v[3] = '{1, 11, 0, 1, 21, 1, 1, 0, 1, 11, 0};
        v[4] = '{1, 12, 1, 1, 21, 1, 0, 1, 1, 21, 1};
        v[5] = '{1, 641, 1, 0, 0, 0, 1, 0, 1, 641, 1};
        v[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 641, 1};
        v[7] = '{0, 0, 0, 1, 307200, 0, 0, 1, 0, 641, 1};
        v[8] = '{1, 5, 0, 1, 6, 1, 1, 0, 1, 5, 0};
        v[9] = '{0, 0, 0, 1, 307199, 1, 0, 1, 1, 307199, 1};
        #1 rst = 1'b1;
        #1;
        chk("rst_we", bd.fb_we, 0);   chk("rst_addr", bd.fb_addr, 0);  chk("rst_din", bd.fb_din, 0);
        chk("rst_busy", bs.busy, 0);  chk("rst_done", bs.clear_done, 0); chk("rst_s_we", bs.fb_we, 0);
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bd.m_valid = v[i].mv; bd.m_addr = v[i].ma; bd.m_data = v[i].md;
            bd.t_valid = v[i].tv; bd.t_addr = v[i].ta; bd.t_data = v[i].td;
            #1;
            chk($sformatf("vec%0d_m_ready", i), bd.m_ready, v[i].emr);
            chk($sformatf("vec%0d_t_ready", i), bd.t_ready, v[i].etr);
            tick;
            chk($sformatf("vec%0d_fb_we", i), bd.fb_we, v[i].ewe);
            chk($sformatf("vec%0d_fb_addr", i), bd.fb_addr, v[i].ea);
            chk($sformatf("vec%0d_fb_din", i), bd.fb_din, v[i].ed);
        end
        bd.m_valid = 1'b0; bd.t_valid = 1'b0;
        // clear with a mouse write stalled behind it
        bs.clear_req = 1'b1; bs.clear_val = 1'b0;
        bs.m_valid = 1'b1; bs.m_addr = 3; bs.m_data = 1'b1;
        #1;
        chk("clr_accept_m_ready", bs.m_ready, 0);
        tick;
        bs.clear_req = 1'b0;
        bc = 0;
        for (int c = 0; c < 18; c++) begin
            chk($sformatf("clr%0d_we", c), bs.fb_we, c != 0);
            if (c > 0 && c < 17) begin
                chk($sformatf("clr%0d_addr", c), bs.fb_addr, c - 1);
                chk($sformatf("clr%0d_din", c), bs.fb_din, 0);
            end
            if (c == 17) begin
                chk("clr_after_m_addr", bs.fb_addr, 3);
                chk("clr_after_m_din", bs.fb_din, 1);
            end
            chk($sformatf("clr%0d_busy", c), bs.busy, c >= 1 && c <= 16);
            chk($sformatf("clr%0d_done", c), bs.clear_done, c == 16);
            bc += int'(bs.busy);
            if (c < 17) begin
                chk($sformatf("clr%0d_m_ready", c), bs.m_ready, c == 16);
                tick;
                if (c == 16) bs.m_valid = 1'b0;
            end
        end
        chk("clr_busy_cycles", bc, 16);
        // second clear_req mid-clear must not restart or queue
        bs.clear_req = 1'b1; bs.clear_val = 1'b1;
        #1;
        tick;
        bs.clear_req = 1'b0;
        wr = 0; dn = 0; ord = 1;
        for (int c = 0; c < 40; c++) begin
            if (bs.fb_we) begin
                if (bs.fb_addr != wr || bs.fb_din != 1'b1) ord = 0;
                wr++;
            end
            dn += int'(bs.clear_done);
            bs.clear_req = c == 5;
            tick;
        end
        bs.clear_req = 1'b0;
        chk("reclr_writes", wr, 16);
        chk("reclr_done_pulses", dn, 1);
        chk("reclr_in_order", ord, 1);
        // reset mid-clear at counter 7
        bs.clear_req = 1'b1;
        #1;
        tick;
        bs.clear_req = 1'b0;
        for (int c = 0; c < 7; c++) tick;
        chk("mid_busy_before_rst", bs.busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_we", bs.fb_we, 0);
        chk("mid_rst_busy", bs.busy, 0);
        chk("mid_rst_done", bs.clear_done, 0);
        #1 rst = 1'b0;
        bs.m_valid = 1'b1; bs.m_addr = 9; bs.m_data = 1'b1;
        #1;
        chk("post_rst_m_ready", bs.m_ready, 1);
        tick;
        bs.m_valid = 1'b0;
        chk("post_rst_we", bs.fb_we, 1);
        chk("post_rst_addr", bs.fb_addr, 9);
        chk("post_rst_din", bs.fb_din, 1);
        dn = 0; wr = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            dn += int'(bs.clear_done);
            wr += int'(bs.fb_we);
        end
        chk("post_rst_no_done", dn, 0);
        chk("post_rst_no_writes", wr, 0);
        // randomized run against a behavioural model
        pulse_rst;
        pm = 0; pt = 0; mclr = 0; cval = 0; mlt = 1; cidx = 0;
        e_we = 0; e_addr = 0; e_din = 0; e_busy = 0; e_done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pm && $urandom_range(0, 2) == 0) begin
                pm = 1; bs.m_addr = AW'($urandom_range(0, 31)); bs.m_data = 1'($urandom_range(0, 1));
            end
            if (!pt && $urandom_range(0, 2) == 0) begin
                pt = 1; bs.t_addr = AW'($urandom_range(0, 31)); bs.t_data = 1'($urandom_range(0, 1));
            end
            bs.m_valid = pm; bs.t_valid = pt;
            bs.clear_req = $urandom_range(0, 63) == 0;
            bs.clear_val = 1'($urandom_range(0, 1));
            #1;
            arb = !mclr && !bs.clear_req;
            emr = arb && pm && (!pt || mlt);
            etr = arb && pt && (!pm || !mlt);
            chk("rnd_m_ready", bs.m_ready, emr);
            chk("rnd_t_ready", bs.t_ready, etr);
            e_we = 0; e_busy = 0; e_done = 0;
            if (mclr) begin
                e_we = 1; e_addr = cidx; e_din = cval; e_busy = 1; e_done = cidx == SW - 1;
                if (cidx == SW - 1) mclr = 0;
                cidx++;
            end else if (bs.clear_req) begin
                mclr = 1; cidx = 0; cval = bs.clear_val;
            end else if (emr || etr) begin
                a = etr ? int'(bs.t_addr) : int'(bs.m_addr);
                e_we = a < SW;
                if (a < SW) begin
                    e_addr = a;
                    e_din = etr ? bs.t_data : bs.m_data;
                end
                mlt = etr;
            end
            if (emr) pm = 0;
            if (etr) pt = 0;
            tick;
            chk("rnd_we", bs.fb_we, e_we);
            chk("rnd_addr", bs.fb_addr, e_addr);
            chk("rnd_din", bs.fb_din, e_din);
            chk("rnd_busy", bs.busy, e_busy);
            chk("rnd_done", bs.clear_done, e_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
